// File: rtl/ctrl_pkg.sv
// Shared control-bundle types, encodings and bubble constants for the ID-stage
// decoder and its registered ID/EX boundary.
package ctrl_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   localparam logic [2:0] WB_MEM = 3'd1;
   localparam logic [2:0] WB_PC4 = 3'd2;
   localparam logic [2:0] WB_MDU = 3'd4;

   typedef enum logic [2:0] {IMM_I = 3'd0, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_t;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_MDU
   } alu_op_t;

   typedef enum logic [1:0] {SRC_A_RS1 = 2'd0, SRC_A_PC, SRC_A_ZERO} src_a_t;

   typedef enum logic {IDLE = 1'b0, MULTI = 1'b1} fsm_state_t;

   typedef struct packed {
      imm_sel_t imm_sel;
   } id_control_t;

   typedef struct packed {
      src_a_t  alu_src_a;
      logic    alu_src_b;
      alu_op_t alu_control;
      logic    branch;
      logic    jump;
   } ex_control_t;

   typedef struct packed {
      logic       mem_rw;
      logic       mem_read;
      logic [2:0] mem_size;
   } mem_control_t;

   typedef struct packed {
      logic       reg_write;
      logic [2:0] mem_to_reg;
   } wb_control_t;

   typedef struct packed {
      ex_control_t  ex;
      mem_control_t mem;
      wb_control_t  wb;
      logic         valid;
      logic         illegal;
   } id_ex_t;

   localparam id_control_t  ID_BUBBLE    = '0;
   localparam ex_control_t  EX_BUBBLE    = '0;
   localparam mem_control_t MEM_BUBBLE   = '0;
   localparam wb_control_t  WB_BUBBLE    = '0;
   localparam id_ex_t       ID_EX_BUBBLE = '0;

   function automatic alu_op_t alu_base_op(input logic [2:0] fun3);
      case (fun3)
         F3_ADD:  return ALU_ADD;
         F3_SLL:  return ALU_SLL;
         F3_SLT:  return ALU_SLT;
         F3_SLTU: return ALU_SLTU;
         F3_XOR:  return ALU_XOR;
         F3_SR:   return ALU_SRL;
         F3_OR:   return ALU_OR;
         F3_AND:  return ALU_AND;
         default: return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/decode_comb.sv
// Pure combinational RV32I(+M) decoder: control bundles, illegal flag, MDU
// detection and the MDU latency of the decoded op.
module decode_comb
   import ctrl_pkg::*;
#(
   parameter bit          ENABLE_M   = 1'b1,
   parameter int unsigned MUL_CYCLES = 1,
   parameter int unsigned DIV_CYCLES = 8
) (
   input  logic [31:0]  instr,
   output id_control_t  id_ctrl,
   output ex_control_t  ex_ctrl,
   output mem_control_t mem_ctrl,
   output wb_control_t  wb_ctrl,
   output logic         illegal,
   output logic         is_mdu,
   output logic [4:0]   latency
);

   localparam logic [4:0] MUL_LAT = 5'(MUL_CYCLES);
   localparam logic [4:0] DIV_LAT = 5'(DIV_CYCLES);

   logic [6:0] opcode;
   logic [6:0] funct7;
   logic [2:0] fun3;
   logic       unused_fields;

   assign opcode = instr[6:0];
   assign fun3   = instr[14:12];
   assign funct7 = instr[31:25];
   // Register specifiers are consumed by the register file, not by control.
   assign unused_fields = ^{instr[24:15], instr[11:7]};

   always_comb begin
      // NOTE: every output is given a default first so no latch is inferred.
      id_ctrl  = ID_BUBBLE;
      ex_ctrl  = EX_BUBBLE;
      mem_ctrl = MEM_BUBBLE;
      wb_ctrl  = WB_BUBBLE;
      illegal  = 1'b0;
      is_mdu   = 1'b0;
      latency  = 5'd1;
      case (opcode)
         OP_OP: begin
            wb_ctrl.reg_write = 1'b1;
            case (funct7)
               F7_BASE: ex_ctrl.alu_control = alu_base_op(fun3);
               F7_ALT: begin
                  if (fun3 == F3_ADD)     ex_ctrl.alu_control = ALU_SUB;
                  else if (fun3 == F3_SR) ex_ctrl.alu_control = ALU_SRA;
                  else                    illegal = 1'b1;
               end
               F7_MULDIV: begin
                  if (ENABLE_M) begin
                     is_mdu              = 1'b1;
                     ex_ctrl.alu_control = ALU_MDU;
                     wb_ctrl.mem_to_reg  = WB_MDU;
                     latency             = fun3[2] ? DIV_LAT : MUL_LAT;
                  end else begin
                     illegal = 1'b1;
                  end
               end
               default: illegal = 1'b1;
            endcase
         end
         OP_IMM: begin
            id_ctrl.imm_sel     = IMM_I;
            ex_ctrl.alu_src_b   = 1'b1;
            ex_ctrl.alu_control = alu_base_op(fun3);
            wb_ctrl.reg_write   = 1'b1;
            if (fun3 == F3_SLL && funct7 != F7_BASE) illegal = 1'b1;
            if (fun3 == F3_SR) begin
               if (funct7 == F7_ALT)       ex_ctrl.alu_control = ALU_SRA;
               else if (funct7 != F7_BASE) illegal = 1'b1;
            end
         end
         OP_LOAD: begin
            id_ctrl.imm_sel    = IMM_I;
            ex_ctrl.alu_src_b  = 1'b1;
            mem_ctrl.mem_read  = 1'b1;
            mem_ctrl.mem_size  = fun3;
            wb_ctrl.reg_write  = 1'b1;
            wb_ctrl.mem_to_reg = WB_MEM;
            if (fun3 == 3'b011 || fun3[2:1] == 2'b11) illegal = 1'b1;
         end
         OP_STORE: begin
            id_ctrl.imm_sel   = IMM_S;
            ex_ctrl.alu_src_b = 1'b1;
            mem_ctrl.mem_rw   = 1'b1;
            mem_ctrl.mem_size = fun3;
            if (fun3 > 3'b010) illegal = 1'b1;
         end
         OP_BRANCH: begin
            id_ctrl.imm_sel     = IMM_B;
            ex_ctrl.alu_control = ALU_SUB;
            ex_ctrl.branch      = 1'b1;
            if (fun3[2:1] == 2'b01) illegal = 1'b1;
         end
         OP_JAL: begin
            id_ctrl.imm_sel    = IMM_J;
            ex_ctrl.alu_src_a  = SRC_A_PC;
            ex_ctrl.alu_src_b  = 1'b1;
            ex_ctrl.jump       = 1'b1;
            wb_ctrl.reg_write  = 1'b1;
            wb_ctrl.mem_to_reg = WB_PC4;
         end
         OP_JALR: begin
            id_ctrl.imm_sel    = IMM_I;
            ex_ctrl.alu_src_b  = 1'b1;
            ex_ctrl.jump       = 1'b1;
            wb_ctrl.reg_write  = 1'b1;
            wb_ctrl.mem_to_reg = WB_PC4;
         end
         OP_LUI, OP_AUIPC: begin
            id_ctrl.imm_sel   = IMM_U;
            ex_ctrl.alu_src_a = (opcode == OP_LUI) ? SRC_A_ZERO : SRC_A_PC;
            ex_ctrl.alu_src_b = 1'b1;
            wb_ctrl.reg_write = 1'b1;
         end
         default: illegal = 1'b1;
      endcase
      // Compressed/reserved encodings land here too; illegal ops drive all-zero controls.
      if (instr[1:0] != 2'b11) illegal = 1'b1;
      if (illegal) begin
         id_ctrl  = ID_BUBBLE;
         ex_ctrl  = EX_BUBBLE;
         mem_ctrl = MEM_BUBBLE;
         wb_ctrl  = WB_BUBBLE;
         is_mdu   = 1'b0;
         latency  = 5'd1;
      end
   end

endmodule

// File: rtl/decode_ctrl_unit.sv
// Registered ID-stage controller: decoder plus bubble/stall/flush handling and
// a MUL/DIV issue sequencer that holds the front end until the MDU result is due.
module decode_ctrl_unit
   import ctrl_pkg::*;
#(
   parameter bit          ENABLE_M   = 1'b1,
   parameter int unsigned MUL_CYCLES = 1,
   parameter int unsigned DIV_CYCLES = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [31:0]  instr_i,
   input  logic         instr_valid_i,
   input  logic         stall_i,
   input  logic         flush_i,
   output id_control_t  id_ctrl_o,
   output ex_control_t  ex_ctrl_o,
   output mem_control_t mem_ctrl_o,
   output wb_control_t  wb_ctrl_o,
   output logic         ctrl_valid_o,
   output logic         illegal_o,
   output logic         stall_req_o,
   output logic         mdu_start_o,
   output logic [2:0]   mdu_op_o,
   output logic         mdu_abort_o
);

   ex_control_t  dec_ex;
   mem_control_t dec_mem;
   wb_control_t  dec_wb;
   logic         dec_illegal;
   logic         dec_is_mdu;
   logic [4:0]   dec_latency;

   fsm_state_t state_q, state_d;
   logic [4:0] cnt_q, cnt_d;
   id_ex_t     id_ex_q, id_ex_d;
   id_ex_t     id_ex_load;

   decode_comb #(
      .ENABLE_M   (ENABLE_M),
      .MUL_CYCLES (MUL_CYCLES),
      .DIV_CYCLES (DIV_CYCLES)
   ) u_decode (
      .instr    (instr_i),
      .id_ctrl  (id_ctrl_o),
      .ex_ctrl  (dec_ex),
      .mem_ctrl (dec_mem),
      .wb_ctrl  (dec_wb),
      .illegal  (dec_illegal),
      .is_mdu   (dec_is_mdu),
      .latency  (dec_latency)
   );

   assign id_ex_load = '{ex: dec_ex, mem: dec_mem, wb: dec_wb, valid: 1'b1, illegal: 1'b0};

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      id_ex_d     = id_ex_q;
      mdu_start_o = 1'b0;
      mdu_abort_o = 1'b0;
      if (flush_i) begin
         id_ex_d     = ID_EX_BUBBLE;
         state_d     = IDLE;
         cnt_d       = 5'd0;
         mdu_abort_o = (state_q == MULTI);
      end else if (!stall_i) begin
         id_ex_d = ID_EX_BUBBLE;
         case (state_q)
            IDLE: begin
               if (instr_valid_i) begin
                  if (dec_illegal) begin
                     id_ex_d.illegal = 1'b1;
                  end else if (dec_is_mdu && dec_latency > 5'd1) begin
                     mdu_start_o = 1'b1;
                     cnt_d       = dec_latency - 5'd1;
                     state_d     = MULTI;
                  end else begin
                     mdu_start_o = dec_is_mdu;
                     id_ex_d     = id_ex_load;
                  end
               end
            end
            MULTI: begin
               // IF/ID is held, so instr_i still carries the in-flight M op.
               cnt_d = cnt_q - 5'd1;
               if (cnt_q == 5'd1) begin
                  id_ex_d = id_ex_load;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
      // The pulses are combinational from instr_i, so reset must mask them directly.
      if (rst) begin
         mdu_start_o = 1'b0;
         mdu_abort_o = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 5'd0;
         id_ex_q <= ID_EX_BUBBLE;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         id_ex_q <= id_ex_d;
      end
   end

   assign ex_ctrl_o    = id_ex_q.ex;
   assign mem_ctrl_o   = id_ex_q.mem;
   assign wb_ctrl_o    = id_ex_q.wb;
   assign ctrl_valid_o = id_ex_q.valid;
   assign illegal_o    = id_ex_q.illegal;
   assign stall_req_o  = (state_q == MULTI);
   assign mdu_op_o     = mdu_start_o ? instr_i[14:12] : 3'b000;

endmodule

// File: doc/decode_ctrl_unit.md
# decode_ctrl_unit

Registered successor to the combinational ID-stage controller. Decodes RV32I plus optional M-extension instructions from the IF/ID register. Drives ImmSel combinationally and registers the EX/MEM/WB control bundles into the ID/EX boundary. Adds the following, none of which the current controller has:
- illegal-instruction detection;
- deterministic bubble insertion (no X outputs);
- stall/flush handling;
- a multi-cycle MUL/DIV issue sequencer that holds the front end until the MDU result is due.

## Interface
Parameters:
- ENABLE_M, 1: 1 accepts funct7=0000001 R-type (M ops); 0 flags them illegal.
- MUL_CYCLES, 1: MDU latency for MUL* (1 = single-cycle, no stall).
- DIV_CYCLES, 8: MDU latency for DIV*/REM*; must be ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. **One clock; reset is asynchronous and active-high.**
- instr_i  in  32  instruction from IF/ID.
- instr_valid_i  in  1  instr_i holds a real instruction.
- stall_i  in  1  downstream hazard hold; freeze all state.
- flush_i  in  1  kill the ID-stage instruction (branch taken / trap).
- id_ctrl_o  out  id_control_t  combinational ImmSel for this-cycle immgen.
- ex_ctrl_o / mem_ctrl_o / wb_ctrl_o  out  bundles  registered controls into ID/EX.
- ctrl_valid_o  out  1  registered bundles belong to a real instruction.
- illegal_o  out  1  registered one-cycle pulse: the last accepted instruction was illegal.
- stall_req_o  out  1  hold PC and IF/ID (combinational from state).
- mdu_start_o  out  1  one-cycle pulse: launch MDU op.
- mdu_op_o  out  3  funct3 of the MDU op, valid with mdu_start_o.
- mdu_abort_o  out  1  one-cycle pulse: cancel the in-flight MDU op.

## Operation
- Decode rules:
  - Per-opcode control values are unchanged from the current controller.
  - All don't-care fields are driven to 0.
  - ALUControl for M ops is `ALU_MDU`; MemtoReg selects the MDU result (value 3'd4; MemtoReg is widened to 3 bits).
- Illegal, any of:
  - instr[1:0]≠2'b11;
  - unknown opcode;
  - R-type funct7 not in {0000000, 0100000, 0000001 when ENABLE_M};
  - funct7=0100000 with fun3∉{000,101};
  - OP-IMM shift with instr[31:25] not in {0000000, 0100000 (SRAI only)};
  - branch fun3∈{010,011};
  - load fun3∈{011,110,111};
  - store fun3>010.
  - Response: register a bubble with ctrl_valid_o=0 and pulse illegal_o.
- Bubble: RegWrite=0, MemRW=0, Jump=0, Branch=0, all other fields 0.
- FSM states IDLE and MULTI, with 5-bit down-counter cnt.
  - IDLE, valid non-M or single-cycle op: register the bundle; ctrl_valid_o=1 next cycle.
  - IDLE, valid M op with latency L>1: pulse mdu_start_o; load cnt=L-1; go MULTI. The registered output this cycle is a bubble.
  - MULTI: stall_req_o=1; cnt decrements each cycle. In the cycle cnt==1, register the M op bundle (ctrl_valid_o=1 next cycle) and return to IDLE.
  - A single-cycle MUL (MUL_CYCLES=1) pulses mdu_start_o and registers the bundle in the same cycle.
- Priority: rst > flush_i > stall_i > normal.
  - flush_i: register a bubble; no illegal_o pulse; state→IDLE, cnt→0. If in MULTI, pulse mdu_abort_o. No mdu_start_o in the flush cycle.
  - stall_i (no flush): registered outputs, state and cnt hold; mdu_start_o suppressed; stall_req_o keeps its state-based value.
- instr_valid_i=0 in IDLE registers a bubble.

## Timing
- Reset values:
  - all registered bundles = bubble;
  - ctrl_valid_o=0, illegal_o=0, mdu_start_o=0, mdu_abort_o=0;
  - state=IDLE, cnt=0;
  - stall_req_o=0.
- id_ctrl_o: zero latency from instr_i.
- ex/mem/wb bundles: 1-cycle latency for normal ops. An M op of latency L reaches ID/EX L cycles after entering ID.
- stall_req_o rises the cycle after mdu_start_o and falls the cycle after the bundle is registered. Total front-end hold = L-1 cycles.
- Reset asserted mid-MULTI: immediate return to reset values; no abort pulse.
- flush_i with stall_i both high: flush wins.

## Structure
- ctrl_pkg holds:
  - id/ex/mem/wb control typedefs (MemtoReg widened to 3 bits);
  - fsm_state_t enum;
  - `ALU_MDU`;
  - the bubble constant for each bundle;
  - opcode/fun3/funct7 constants.
- Sub-module decode_comb: the pure combinational decoder, producing bundles, illegal, is_mdu and latency. The top holds the FSM, counter and output registers.

## Test plan
- Reset: assert rst mid-cycle → all outputs at reset values immediately; ctrl_valid_o=0.
- ADD x3,x1,x2 (0x002081B3) valid → next cycle: RegWrite=1, ALUSrcB=0, ctrl_valid_o=1, stall_req_o=0.
- DIV x5,x6,x7 (0x027342B3), DIV_CYCLES=8 → mdu_start_o pulse with mdu_op_o=3'b100; stall_req_o high 7 cycles; bundle with MemtoReg=4 registered at cycle 8.
- Illegal 0x00000000 and funct7=0100000 with fun3=001 → bubble, illegal_o one-cycle pulse, ctrl_valid_o=0.
- Flush at MULTI cnt=3 → mdu_abort_o pulse, state IDLE, stall_req_o=0 next cycle, bubble registered.
- stall_i held 3 cycles during MULTI → cnt frozen; total stall_req_o window extends by exactly 3 cycles.
